// File: rtl/rv64_wb_pkg.sv
// Shared types for the integer register-file writeback path.
// Provides XLEN default, the writeback request bundle and the x0 index.
package rv64_wb_pkg;

  localparam int XLEN = 64;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_writeback_arbiter_fifo.sv
// In-order buffer for memory/long-op writeback requests (wb_fifo).
// Ports: push/din, pop/head, full/empty, per-entry valid and rd vectors.
module wb_fifo
  import rv64_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_req_t               din,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      ent_vld,
  output logic [DEPTH-1:0][4:0] ent_rd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; validity comes from cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Entry i is live when its distance from the head is below cnt.
  always_comb begin
    logic [AW-1:0] off;
    ent_vld = '0;
    ent_rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = AW'(i) - rd_ptr;
      ent_vld[i] = ({1'b0, off} < cnt);
      ent_rd[i]  = mem[i].rd;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and memory result streams onto the single regfile write port.
// Ports: alu_*/mem_* valid-ready sources, wb_* write port, pending_mask.
// Optional WB_BYPASS_EN: memory result skips an empty FIFO when ALU idle.
module regfile_writeback_arbiter #(
  parameter int XLEN           = 64,
  parameter int MEM_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_enable,
  output logic [31:0]     pending_mask
);

  import rv64_wb_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t                       alu_req;
  wb_req_t                       mem_req;
  wb_req_t                       f_head;
  wb_req_t                       win_req;
  logic                          f_full;
  logic                          f_empty;
  logic [MEM_FIFO_DEPTH-1:0]     f_vld;
  logic [MEM_FIFO_DEPTH-1:0][4:0] f_rd;
  logic                          push;
  logic                          pop;
  logic                          alu_win;
  logic                          fifo_win;
  logic                          byp;
  logic                          win;
  logic                          starve_hit;
  logic [SW-1:0]                 starve_cnt;

  assign alu_req.rd   = alu_rd;
  assign alu_req.data = alu_data;
  assign mem_req.rd   = mem_rd;
  assign mem_req.data = mem_data;

  wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (mem_req),
    .pop     (pop),
    .head    (f_head),
    .full    (f_full),
    .empty   (f_empty),
    .ent_vld (f_vld),
    .ent_rd  (f_rd)
  );

  always_comb begin
    starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
    fifo_win   = !rst && !f_empty && (!alu_valid || starve_hit);
    alu_win    = !rst && alu_valid && !fifo_win;
`ifdef WB_BYPASS_EN
    byp        = !rst && f_empty && !alu_valid && mem_valid;
`else
    byp        = 1'b0;
`endif
    pop        = fifo_win;
    mem_ready  = !rst && (!f_full || pop);
    push       = mem_valid && mem_ready && !byp;
    alu_ready  = alu_win;
    win        = alu_win || fifo_win || byp;
    unique case (1'b1)
      alu_win:  win_req = alu_req;
      fifo_win: win_req = f_head;
      default:  win_req = mem_req;
    endcase
  end

  // Held at zero in reset so issue never sees stale queued writes.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
      if (f_vld[i]) pending_mask[f_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
    if (rst) pending_mask = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (f_empty || fifo_win) begin
      starve_cnt <= '0;
    end else if (alu_win && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_enable <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      wb_enable <= win && (win_req.rd != REG_ZERO);
      if (win) begin
        wb_rd   <= win_req.rd;
        wb_data <= win_req.data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed self-checking bench for regfile_writeback_arbiter.
// Expectations follow the default build unless WB_BYPASS_EN is defined.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_enable;
  logic [31:0] pending_mask;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(
    .XLEN           (64),
    .MEM_FIFO_DEPTH (2),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_enable    (wb_enable),
    .pending_mask (pending_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    alu_data  = 64'h1;
    mem_valid = 1'b1;
    mem_rd    = 5'd2;
    mem_data  = 64'h2;
    tick();
    tick();
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_pending", pending_mask, 0);
    chk("rst_wb_en", wb_enable, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    rst       = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("idle_mem_ready", mem_ready, 1);
    chk("idle_alu_ready", alu_ready, 0);

    // ALU only
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 64'hDEAD;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alu_ready", alu_ready, 1);
      chk("alu_mem_ready", mem_ready, 1);
      tick();
      chk("alu_wb_en", wb_enable, 1);
      chk("alu_wb_rd", wb_rd, 5);
      chk("alu_wb_data", wb_data, 64'hDEAD);
    end
    alu_valid = 1'b0;
    tick();
    chk("alu_idle_wb_en", wb_enable, 0);

    // Memory only
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 64'h1234;
    #1;
    chk("mem_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_pending", pending_mask, 0);
    chk("byp_wb_en", wb_enable, 1);
    chk("byp_wb_rd", wb_rd, 7);
    chk("byp_wb_data", wb_data, 64'h1234);
    tick();
    chk("byp_after_wb_en", wb_enable, 0);
`else
    chk("mem_pending7", pending_mask, 32'h80);
    chk("mem_wb_en_n1", wb_enable, 0);
    tick();
    chk("mem_wb_en", wb_enable, 1);
    chk("mem_wb_rd", wb_rd, 7);
    chk("mem_wb_data", wb_data, 64'h1234);
    chk("mem_pending_clr", pending_mask, 0);
`endif

    // Starvation guard
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 64'h99;
    mem_valid = 1'b1;
    mem_rd    = 5'd3;
    mem_data  = 64'h33;
    #1;
    chk("stv_first_alu", alu_ready, 1);
    tick();
    mem_valid = 1'b0;
    chk("stv_first_wb", wb_rd, 9);
    chk("stv_pending3", pending_mask, 32'h8);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stv_alu_ready", alu_ready, 1);
      tick();
      chk("stv_alu_wb", wb_rd, 9);
    end
    #1;
    chk("stv_alu_blocked", alu_ready, 0);
    tick();
    chk("stv_fifo_wb_rd", wb_rd, 3);
    chk("stv_fifo_wb_data", wb_data, 64'h33);
    chk("stv_fifo_wb_en", wb_enable, 1);
    #1;
    chk("stv_alu_resume", alu_ready, 1);
    tick();
    chk("stv_resume_wb", wb_rd, 9);

    // Backpressure with continuous ALU
    mem_valid = 1'b1;
    mem_rd    = 5'd10;
    mem_data  = 64'hA;
    #1;
    chk("bp_rdy1", mem_ready, 1);
    tick();
    mem_rd   = 5'd11;
    mem_data = 64'hB;
    #1;
    chk("bp_rdy2", mem_ready, 1);
    tick();
    mem_rd   = 5'd12;
    mem_data = 64'hC;
    #1;
    chk("bp_full", mem_ready, 0);
    chk("bp_pending", pending_mask, 32'h0C00);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("bp_hold", mem_ready, 0);
      tick();
    end
    chk("bp_pop_rdy", mem_ready, 1);
    chk("bp_pop_alu", alu_ready, 0);
    tick();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    chk("bp_wb_a_rd", wb_rd, 10);
    chk("bp_wb_a_data", wb_data, 64'hA);
    #1;
    chk("bp_pending2", pending_mask, 32'h1800);
    tick();
    chk("bp_wb_b_rd", wb_rd, 11);
    chk("bp_wb_b_data", wb_data, 64'hB);
    tick();
    chk("bp_wb_c_rd", wb_rd, 12);
    chk("bp_wb_c_data", wb_data, 64'hC);
    chk("bp_pending0", pending_mask, 0);

    // x0 writes
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 64'hFF;
    #1;
    chk("x0_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("x0_alu_wb_en", wb_enable, 0);
    mem_valid = 1'b1;
    mem_rd    = 5'd0;
    mem_data  = 64'h5;
    #1;
    chk("x0_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0;
    chk("x0_pending", pending_mask, 0);
    tick();
    chk("x0_mem_wb_en", wb_enable, 0);
    chk("x0_drained", mem_ready, 1);

    // Reset with two queued entries
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 64'h99;
    mem_valid = 1'b1;
    mem_rd    = 5'd20;
    mem_data  = 64'h20;
    tick();
    mem_rd   = 5'd21;
    mem_data = 64'h21;
    tick();
    mem_valid = 1'b0;
    #1;
    chk("mr_pending", pending_mask, 32'h0030_0000);
    rst = 1'b1;
    #1;
    chk("mr_rst_pending", pending_mask, 0);
    chk("mr_rst_mem_ready", mem_ready, 0);
    chk("mr_rst_alu_ready", alu_ready, 0);
    tick();
    rst       = 1'b0;
    alu_valid = 1'b0;
    #1;
    chk("mr_wb_en", wb_enable, 0);
    chk("mr_pending0", pending_mask, 0);
    chk("mr_mem_ready", mem_ready, 1);
    tick();
    chk("mr_no_write", wb_enable, 0);
    tick();
    chk("mr_still_idle", wb_enable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
